// File: rtl/pkt_tx_sched_pkg.sv
// Shared types and constants for the transmit scheduler that sits in front of the OutFIFO stream port.
// Includes the FIFO status/command records, the UDP header record and the scheduler state encoding.
package pkt_tx_sched_pkg;

  localparam int unsigned OUTFIFO_KB_SIZE    = 32'd4;
  localparam int unsigned PKT_TX_TIMEOUT_DEF = 32'd65535;

  typedef logic [15:0] ptr_t;
  typedef logic [15:0] udp_length_t;

  typedef struct packed {
    ptr_t rd_ptr;
    ptr_t wr_ptr;
    logic empty;
    logic full;
    logic done;
  } s_fifo_st_t;

  typedef struct packed {
    logic        start;
    udp_length_t length;
    logic        clear;
  } s_fifo_cmd_t;

  typedef struct packed {
    udp_length_t len;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [15:0] src_port;
  } s_udp_tx_hdr_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    HDR       = 3'd2,
    STREAM    = 3'd3,
    DONE      = 3'd4
  } fsm_tx_sched_t;

  // Bytes currently held in the OutFIFO; modular subtraction keeps it correct across pointer wrap.
  function automatic ptr_t fifo_occupancy(input s_fifo_st_t st);
    return st.wr_ptr - st.rd_ptr;
  endfunction

endpackage

// File: rtl/pkt_tx_sched_if.sv
// Bundle of request, UDP header, OutFIFO and control signals around pkt_tx_sched.
// master is the scheduler side, slave is the surrounding environment.
interface pkt_tx_sched_if;
  import pkt_tx_sched_pkg::*;

  logic          req_valid_i;
  logic          req_ready_o;
  udp_length_t   req_len_i;
  logic [31:0]   req_dst_ip_i;
  logic [15:0]   req_dst_port_i;
  logic [15:0]   req_src_port_i;
  logic          hdr_valid_o;
  logic          hdr_ready_i;
  s_udp_tx_hdr_t hdr_o;
  s_fifo_st_t    fifo_st_i;
  s_fifo_cmd_t   fifo_cmd_o;
  logic          flush_i;
  logic          busy_o;
  logic          err_len_o;
  logic [31:0]   sent_cnt_o;

  modport master (
    input  req_valid_i, req_len_i, req_dst_ip_i, req_dst_port_i, req_src_port_i,
    input  hdr_ready_i, fifo_st_i, flush_i,
    output req_ready_o, hdr_valid_o, hdr_o, fifo_cmd_o, busy_o, err_len_o, sent_cnt_o
  );

  modport slave (
    output req_valid_i, req_len_i, req_dst_ip_i, req_dst_port_i, req_src_port_i,
    output hdr_ready_i, fifo_st_i, flush_i,
    input  req_ready_o, hdr_valid_o, hdr_o, fifo_cmd_o, busy_o, err_len_o, sent_cnt_o
  );

endinterface

// File: rtl/pkt_tx_sched.sv
// Transmit scheduler: accepts one send request, waits for payload in the OutFIFO, hands the UDP header
// to the stack, streams the packet and counts it. Optional watchdog abort: PKT_TX_SCHED_TIMEOUT_EN.
module pkt_tx_sched
  import pkt_tx_sched_pkg::*;
#(
  parameter int unsigned MAX_LEN        = OUTFIFO_KB_SIZE * 32'd1024,
  parameter int unsigned TIMEOUT_CYCLES = PKT_TX_TIMEOUT_DEF
) (
  input logic            clk,
  input logic            rst,
  pkt_tx_sched_if.master bus
);

  fsm_tx_sched_t state_r;
  fsm_tx_sched_t state_nx_s;
  s_udp_tx_hdr_t req_r;
  s_fifo_cmd_t   cmd_r;
  logic          ready_r;
  logic          busy_r;
  logic          hdr_valid_r;
  logic          err_len_r;
  logic          flush_pend_r;
  logic [31:0]   sent_cnt_r;

  logic          req_ready_s;
  logic          accept_s;
  logic          len_bad_s;
  logic          data_ready_s;
  logic          flush_req_s;
  logic          clear_s;
  logic          reject_s;
  logic          abort_s;
  logic          tmo_hit_s;
  logic          unused_s;

  // A flush seen outside IDLE is parked in flush_pend_r and also blocks new requests until issued.
  assign req_ready_s  = ready_r && !bus.flush_i && !flush_pend_r;
  assign accept_s     = (state_r == IDLE) && bus.req_valid_i && req_ready_s;
  assign len_bad_s    = (bus.req_len_i == 16'd0) || (32'(bus.req_len_i) > MAX_LEN);
  assign data_ready_s = (fifo_occupancy(bus.fifo_st_i) >= req_r.len);
  assign flush_req_s  = bus.flush_i || flush_pend_r;
  assign clear_s      = ((state_r == IDLE) && flush_req_s) || abort_s;
  assign unused_s     = &{1'b0, bus.fifo_st_i.empty, bus.fifo_st_i.full, (TIMEOUT_CYCLES != 32'd0)};

`ifdef PKT_TX_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;

  assign tmo_hit_s = ((state_r == WAIT_DATA) || (state_r == STREAM)) &&
                     (32'(tmo_cnt_r) >= (TIMEOUT_CYCLES - 32'd1));

  // Watchdog counts cycles spent in the current waiting state and restarts on every transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_nx_s != state_r) begin
      tmo_cnt_r <= 16'd0;
    end else if ((state_r == WAIT_DATA) || (state_r == STREAM)) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= 16'd0;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; forward progress takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_nx_s = state_r;
    reject_s   = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (len_bad_s) begin
            reject_s = 1'b1;
          end else begin
            state_nx_s = WAIT_DATA;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT_DATA: begin
        if (data_ready_s) begin
          state_nx_s = HDR;
        end else if (tmo_hit_s) begin
          abort_s    = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_DATA;
        end
      end
      HDR: begin
        if (bus.hdr_ready_i) begin
          state_nx_s = STREAM;
        end else begin
          state_nx_s = HDR;
        end
      end
      STREAM: begin
        if (bus.fifo_st_i.done) begin
          state_nx_s = DONE;
        end else if (tmo_hit_s) begin
          abort_s    = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = STREAM;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Request fields are captured only at acceptance and then held for the whole packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_r <= '0;
    end else if (accept_s) begin
      req_r <= '{len:      bus.req_len_i,
                 dst_ip:   bus.req_dst_ip_i,
                 dst_port: bus.req_dst_port_i,
                 src_port: bus.req_src_port_i};
    end else begin
      req_r <= req_r;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
      hdr_valid_r  <= 1'b0;
      cmd_r        <= '0;
      err_len_r    <= 1'b0;
      flush_pend_r <= 1'b0;
      sent_cnt_r   <= 32'd0;
    end else begin
      ready_r      <= (state_nx_s == IDLE);
      busy_r       <= (state_nx_s != IDLE);
      hdr_valid_r  <= (state_nx_s == HDR);
      cmd_r.start  <= (state_nx_s == STREAM);
      cmd_r.length <= (state_nx_s == STREAM) ? req_r.len : 16'd0;
      cmd_r.clear  <= clear_s;
      err_len_r    <= reject_s || abort_s;
      flush_pend_r <= (state_r == IDLE) ? 1'b0 : flush_req_s;
      if ((state_r == STREAM) && (state_nx_s == DONE)) begin
        sent_cnt_r <= sent_cnt_r + 32'd1;
      end else begin
        sent_cnt_r <= sent_cnt_r;
      end
    end
  end

  assign bus.req_ready_o = req_ready_s;
  assign bus.hdr_valid_o = hdr_valid_r;
  assign bus.hdr_o       = req_r;
  assign bus.fifo_cmd_o  = cmd_r;
  assign bus.busy_o      = busy_r;
  assign bus.err_len_o   = err_len_r;
  assign bus.sent_cnt_o  = sent_cnt_r;

endmodule

// File: tb/tb_pkt_tx_sched.sv
// Scoreboard bench for pkt_tx_sched: accepted requests push their expected header, header handshakes pop it.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pkt_tx_sched;
  import pkt_tx_sched_pkg::*;

  localparam int unsigned TB_MAX_LEN = 32'd4096;

  logic clk;
  logic rst;
  pkt_tx_sched_if bus ();

  pkt_tx_sched #(
    .MAX_LEN        (TB_MAX_LEN),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  int unsigned   exp_sent = 0;
  s_udp_tx_hdr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ptrs(input logic [15:0] rd, input logic [15:0] wr);
    bus.fifo_st_i.rd_ptr = rd;
    bus.fifo_st_i.wr_ptr = wr;
  endtask

  // Present one request for one cycle, then scramble the fields to prove they are not re-sampled.
  task automatic drive_req(input logic [15:0] len, input logic [31:0] ip, input logic [15:0] dp,
                           input logic [15:0] sp, input bit ok);
    s_udp_tx_hdr_t h;
    bus.req_valid_i    = 1'b1;
    bus.req_len_i      = len;
    bus.req_dst_ip_i   = ip;
    bus.req_dst_port_i = dp;
    bus.req_src_port_i = sp;
    #1;
    check_eq("req_ready", 80'(bus.req_ready_o), 80'(1'b1));
    h.len = len; h.dst_ip = ip; h.dst_port = dp; h.src_port = sp;
    if (ok) exp_q.push_back(h);
    tick();
    bus.req_valid_i    = 1'b0;
    bus.req_len_i      = 16'($urandom);
    bus.req_dst_ip_i   = $urandom;
    bus.req_dst_port_i = 16'($urandom);
    bus.req_src_port_i = 16'($urandom);
  endtask

  // Wait for the header, compare it with the scoreboard and complete the handshake into STREAM.
  task automatic take_hdr(output s_udp_tx_hdr_t exp);
    int n = 0;
    while (!bus.hdr_valid_o && n < 50) begin
      tick();
      n++;
    end
    check_eq("hdr_valid_wait", 80'(bus.hdr_valid_o), 80'(1'b1));
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
    end else begin
      exp = '0;
      check_eq("scoreboard_empty", 80'(exp_q.size()), 80'(1));
    end
    check_eq("hdr_o", 80'(bus.hdr_o), 80'(exp));
    bus.hdr_ready_i = 1'b1;
    tick();
    bus.hdr_ready_i = 1'b0;
    check_eq("hdr_valid_drop", 80'(bus.hdr_valid_o), 80'(1'b0));
    check_eq("start", 80'(bus.fifo_cmd_o.start), 80'(1'b1));
    check_eq("length", 80'(bus.fifo_cmd_o.length), 80'(exp.len));
  endtask

  task automatic finish_pkt();
    s_udp_tx_hdr_t exp;
    take_hdr(exp);
    repeat (3) tick();
    check_eq("start_hold", 80'(bus.fifo_cmd_o.start), 80'(1'b1));
    check_eq("length_hold", 80'(bus.fifo_cmd_o.length), 80'(exp.len));
    bus.fifo_st_i.done = 1'b1;
    tick();
    bus.fifo_st_i.done = 1'b0;
    exp_sent++;
    check_eq("start_low_done", 80'(bus.fifo_cmd_o.start), 80'(1'b0));
    check_eq("sent_cnt", 80'(bus.sent_cnt_o), 80'(exp_sent));
    check_eq("ready_in_done", 80'(bus.req_ready_o), 80'(1'b0));
    tick();
    check_eq("ready_after_done", 80'(bus.req_ready_o), 80'(1'b1));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, 80'(bus.req_ready_o), 80'(1'b0));
    check_eq({tag, "_hdr_valid"}, 80'(bus.hdr_valid_o), 80'(1'b0));
    check_eq({tag, "_hdr_o"}, 80'(bus.hdr_o), 80'(0));
    check_eq({tag, "_cmd"}, 80'(bus.fifo_cmd_o), 80'(0));
    check_eq({tag, "_busy"}, 80'(bus.busy_o), 80'(1'b0));
    check_eq({tag, "_err"}, 80'(bus.err_len_o), 80'(1'b0));
    check_eq({tag, "_sent"}, 80'(bus.sent_cnt_o), 80'(0));
  endtask

  initial begin
    s_udp_tx_hdr_t h;
    int clr_cnt;
    int n;

    rst                = 1'b0;
    bus.req_valid_i    = 1'b0;
    bus.req_len_i      = 16'd0;
    bus.req_dst_ip_i   = 32'd0;
    bus.req_dst_port_i = 16'd0;
    bus.req_src_port_i = 16'd0;
    bus.hdr_ready_i    = 1'b0;
    bus.fifo_st_i      = '0;
    bus.flush_i        = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) tick();
    check_eq("idle_ready", 80'(bus.req_ready_o), 80'(1'b1));
    check_eq("idle_busy", 80'(bus.busy_o), 80'(1'b0));

    // Data already present: header two cycles after accept.
    set_ptrs(16'd0, 16'd64);
    drive_req(16'd64, 32'hC0A8_0001, 16'd1234, 16'd5678, 1'b1);
    check_eq("lat_hdr_c1", 80'(bus.hdr_valid_o), 80'(1'b0));
    check_eq("busy_c1", 80'(bus.busy_o), 80'(1'b1));
    tick();
    check_eq("lat_hdr_c2", 80'(bus.hdr_valid_o), 80'(1'b1));
    tick();
    check_eq("hdr_valid_hold", 80'(bus.hdr_valid_o), 80'(1'b1));
    finish_pkt();

    // Not enough data: stay waiting, then proceed once wr_ptr advances.
    set_ptrs(16'd100, 16'd110);
    drive_req(16'd20, 32'h0A00_0002, 16'd53, 16'd4000, 1'b1);
    repeat (5) begin
      check_eq("wait_no_hdr", 80'(bus.hdr_valid_o), 80'(1'b0));
      tick();
    end
    check_eq("wait_busy", 80'(bus.busy_o), 80'(1'b1));
    set_ptrs(16'd100, 16'd120);
    tick();
    check_eq("hdr_after_data", 80'(bus.hdr_valid_o), 80'(1'b1));
    finish_pkt();

    // Pointer wrap: occupancy 8.
    set_ptrs(16'hFFFC, 16'h0004);
    drive_req(16'd8, 32'hDEAD_BEEF, 16'hFFFF, 16'h0001, 1'b1);
    tick();
    check_eq("wrap_hdr", 80'(bus.hdr_valid_o), 80'(1'b1));
    finish_pkt();

    // Length bounds.
    drive_req(16'd0, 32'h1111_1111, 16'd1, 16'd2, 1'b0);
    check_eq("len0_err", 80'(bus.err_len_o), 80'(1'b1));
    check_eq("len0_busy", 80'(bus.busy_o), 80'(1'b0));
    tick();
    check_eq("len0_err_pulse", 80'(bus.err_len_o), 80'(1'b0));
    check_eq("len0_no_hdr", 80'(bus.hdr_valid_o), 80'(1'b0));
    drive_req(16'(TB_MAX_LEN + 32'd1), 32'h2222_2222, 16'd3, 16'd4, 1'b0);
    check_eq("lenmax1_err", 80'(bus.err_len_o), 80'(1'b1));
    check_eq("lenmax1_busy", 80'(bus.busy_o), 80'(1'b0));
    tick();
    check_eq("lenmax1_err_pulse", 80'(bus.err_len_o), 80'(1'b0));
    check_eq("lenmax1_no_hdr", 80'(bus.hdr_valid_o), 80'(1'b0));
    check_eq("len_err_sent", 80'(bus.sent_cnt_o), 80'(exp_sent));
    set_ptrs(16'd0, 16'(TB_MAX_LEN));
    drive_req(16'(TB_MAX_LEN), 32'h3333_3333, 16'd5, 16'd6, 1'b1);
    check_eq("lenmax_err", 80'(bus.err_len_o), 80'(1'b0));
    finish_pkt();

    // Flush during STREAM is deferred until back in IDLE, then issued once.
    set_ptrs(16'd0, 16'd64);
    drive_req(16'd64, 32'h4444_4444, 16'd7, 16'd8, 1'b1);
    take_hdr(h);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    clr_cnt = 0;
    repeat (3) begin
      if (bus.fifo_cmd_o.clear) clr_cnt++;
      tick();
    end
    check_eq("clear_deferred", 80'(clr_cnt), 80'(0));
    bus.fifo_st_i.done = 1'b1;
    tick();
    bus.fifo_st_i.done = 1'b0;
    exp_sent++;
    check_eq("flush_sent", 80'(bus.sent_cnt_o), 80'(exp_sent));
    repeat (6) begin
      if (bus.fifo_cmd_o.clear) clr_cnt++;
      tick();
    end
    check_eq("clear_once", 80'(clr_cnt), 80'(1));

    // Flush and request together in IDLE: flush wins.
    bus.flush_i     = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_len_i   = 16'd16;
    #1;
    check_eq("ready_flush", 80'(bus.req_ready_o), 80'(1'b0));
    tick();
    bus.flush_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    check_eq("clear_idle", 80'(bus.fifo_cmd_o.clear), 80'(1'b1));
    check_eq("flush_not_busy", 80'(bus.busy_o), 80'(1'b0));
    tick();
    check_eq("clear_idle_pulse", 80'(bus.fifo_cmd_o.clear), 80'(1'b0));
    check_eq("flush_no_hdr", 80'(bus.hdr_valid_o), 80'(1'b0));

`ifdef PKT_TX_SCHED_TIMEOUT_EN
    // Stuck STREAM aborts after 100 cycles without counting the packet.
    drive_req(16'd32, 32'h5555_5555, 16'd9, 16'd10, 1'b1);
    take_hdr(h);
    n = 0;
    while (!bus.fifo_cmd_o.clear && n < 300) begin
      tick();
      n++;
    end
    check_eq("tmo_cycles", 80'(n), 80'(100));
    check_eq("tmo_err", 80'(bus.err_len_o), 80'(1'b1));
    check_eq("tmo_busy", 80'(bus.busy_o), 80'(1'b0));
    check_eq("tmo_sent", 80'(bus.sent_cnt_o), 80'(exp_sent));
    tick();
`endif

    // Asynchronous reset in the middle of STREAM clears every output at once.
    drive_req(16'd48, 32'h6666_6666, 16'd11, 16'd12, 1'b1);
    take_hdr(h);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_sent = 0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    check_eq("post_rst_ready", 80'(bus.req_ready_o), 80'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
